mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Sequences the single shared memory port of the multicycle RISC-V datapath between two requesters:
//  instruction fetch (driven from the control unit's fetch state) and load/store data access.
//  Serialises accesses, times the fixed-latency synchronous memory, and returns completion pulses.
//  Sits between the control unit / datapath and the unified instruction+data memory.
// PARAMETERS
//  ADDR_W   64  address width
//  DATA_W   64  data width (fetch and data ports alike)
//  MEM_LAT  2   cycles from mem_rd strobe to valid mem_rdata; legal 1..15, else elaboration $error
// PORTS
//  clock      in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-low reset (0 = reset)
//  if_req     in   1       fetch request, level; held until if_done
//  if_addr    in   ADDR_W  fetch address, stable while if_req=1
//  if_done    out  1       one-cycle fetch completion pulse
//  if_rdata   out  DATA_W  fetched word, valid with if_done, held until next fetch completion
//  d_req      in   1       data request, level; held until d_done
//  d_we       in   1       1 = store, 0 = load; stable while d_req=1
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_done     out  1       one-cycle data completion pulse
//  d_rdata    out  DATA_W  load data, valid with d_done, held until next load completion
//  mem_addr   out  ADDR_W  memory address (registered)
//  mem_wdata  out  DATA_W  memory write data (registered)
//  mem_rd     out  1       one-cycle read strobe
//  mem_wr     out  1       one-cycle write strobe
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_rd
//  busy       out  1       1 in any state other than IDLE
//  owner      out  1       0 = fetch, 1 = data; current or last granted port
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, all outputs 0, wait counter 0, RR pointer = fetch; mem_rd/mem_wr drop immediately.
//  - FSM: IDLE -> ISSUE -> WAIT (reads only) -> DONE -> IDLE.
//  - IDLE: sample requests; on any req latch winner's addr/wdata/we, set owner, go to ISSUE.
//    Tie (if_req & d_req): data wins (a data phase always belongs to the instruction already fetched).
//  - ISSUE (cycle T+1 after grant at T): mem_addr/mem_wdata valid; mem_rd=1 (load/fetch) or mem_wr=1 (store)
//    for exactly this cycle. Store -> DONE. Read -> WAIT with counter = MEM_LAT.
//  - WAIT: decrement counter; when counter reaches 1 the next edge captures mem_rdata
//    (valid at cycle T+1+MEM_LAT) into if_rdata/d_rdata per owner, then go to DONE.
//  - DONE: pulse if_done or d_done (owner port only) for one cycle; -> IDLE.
//    Read latency grant->done = MEM_LAT+2 cycles; store = 2 cycles; IDLE cycle between transactions.
//  - Store: d_rdata unchanged. mem_addr/mem_wdata hold last values outside ISSUE.
//  - Requester deasserting req mid-transaction: transaction still completes and pulses done.
//  - Requests arriving outside IDLE are ignored until IDLE (no queueing, level protocol).
//  - Async reset mid-transaction aborts it: no done pulse, requester must reissue.
//  - Fixed priority can starve fetch only if d_req is held continuously; the control unit never does this.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: ties resolved round-robin; the port not served last wins; pointer
//    updates in DONE; reset pointer = fetch, so first tie after reset goes to data (fetch last served).
//  Not defined: fixed data-over-fetch priority as above; no pointer register.
// TESTING (MEM_LAT=2)
//  1 reset=0 for 3 cycles, then 1 -> all outputs 0, busy=0; no strobes without requests.
//  2 if_req=1, if_addr=0x100 at cycle 0; mem_rdata=0x00500093 at cycle 3 -> mem_rd=1, mem_addr=0x100 at cycle 1;
//    if_done=1, if_rdata=0x00500093 at cycle 4 only; d_done stays 0.
//  3 d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEAD at cycle 0 -> mem_wr=1, mem_addr=0x200, mem_wdata=0xDEAD
//    at cycle 1; d_done at cycle 2; d_rdata unchanged; mem_rd never asserted.
//  4 if_req and d_req (load, 0x208) both at cycle 0 -> data issued cycle 1, d_done cycle 4;
//    fetch granted in IDLE cycle 5, mem_rd cycle 6 with if_addr, if_done cycle 9.
//  5 MEM_ARB_RR_EN, both reqs held high, re-asserted after each done -> grant order data, fetch, data, fetch.
//  6 if_req read, reset=0 at cycle 2 (WAIT) -> mem_rd/busy 0 immediately, no if_done; after release
//    new if_req 0x104 completes normally in 4 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency synchronous memory port between instruction fetch and load/store access.
// Optional MEM_ARB_RR_EN: round-robin tie resolution instead of fixed data-over-fetch priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
            $error("mem_port_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    logic [1:0]        state_reg;
    logic [3:0]        cnt_reg;
    logic              we_reg;
    logic              owner_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_rd_reg;
    logic              mem_wr_reg;
    logic              if_done_reg;
    logic              d_done_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;
    logic              grant_data;

`ifdef MEM_ARB_RR_EN
    // 1 when the data port was served last; a tie goes to the other port
    logic last_data_reg;

    always_comb begin
        grant_data = d_req && (!if_req || !last_data_reg);
    end
`else
    always_comb begin
        grant_data = d_req;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            we_reg        <= 1'b0;
            owner_reg     <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_rd_reg    <= 1'b0;
            mem_wr_reg    <= 1'b0;
            if_done_reg   <= 1'b0;
            d_done_reg    <= 1'b0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
`ifdef MEM_ARB_RR_EN
            last_data_reg <= 1'b0;
`endif
        end else begin
            // Strobes and done pulses are single-cycle unless re-armed below
            mem_rd_reg  <= 1'b0;
            mem_wr_reg  <= 1'b0;
            if_done_reg <= 1'b0;
            d_done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_reg    <= grant_data;
                        we_reg       <= grant_data && d_we;
                        mem_addr_reg <= grant_data ? d_addr : if_addr;
                        if (grant_data) begin
                            mem_wdata_reg <= d_wdata;
                        end
                        mem_rd_reg   <= !(grant_data && d_we);
                        mem_wr_reg   <= grant_data && d_we;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (we_reg) begin
                        d_done_reg <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg   <= LAT_CNT;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    // Count of 1 marks the cycle in which mem_rdata is valid
                    if (cnt_reg == 4'd1) begin
                        if (owner_reg) begin
                            d_rdata_reg <= mem_rdata;
                            d_done_reg  <= 1'b1;
                        end else begin
                            if_rdata_reg <= mem_rdata;
                            if_done_reg  <= 1'b1;
                        end
                        state_reg <= DONE;
                    end
                end
                DONE: begin
`ifdef MEM_ARB_RR_EN
                    last_data_reg <= owner_reg;
`endif
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign if_done   = if_done_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_done    = d_done_reg;
    assign d_rdata   = d_rdata_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;
    assign busy      = (state_reg != IDLE);
    assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized fetch/load/store traffic
// checked against a transaction-level model of memory contents, latencies and arbitration.
module tb_mem_port_arbiter;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int LAT = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;
    logic          owner;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DW-1:0] sim_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] pend [int];
    logic          ref_last = 1'b0;
    logic [DW-1:0] exp_if_rdata = '0;
    logic [DW-1:0] exp_d_rdata = '0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
    endfunction

    function automatic logic [DW-1:0] sim_read(input logic [AW-1:0] a);
        return sim_mem.exists(a) ? sim_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Memory with fixed read latency: data appears LAT cycles after the strobe, noise otherwise
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            pend.delete();
        end else begin
            if (mem_wr) sim_mem[mem_addr] = mem_wdata;
            if (mem_rd) pend[cyc + LAT] = sim_read(mem_addr);
        end
        if (pend.exists(cyc)) begin
            mem_rdata = pend[cyc];
            pend.delete(cyc);
        end else begin
            mem_rdata = {$urandom, $urandom};
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_last     = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
    endtask

    task automatic run_txn(input bit req_f, input bit req_d, input bit we,
                           input logic [AW-1:0] f_addr, input logic [AW-1:0] dd_addr,
                           input logic [DW-1:0] wdata, input bit drop_early);
        bit is_data, is_store, seen;
        int n, rd_n, wr_n, exp_lat;
        logic [AW-1:0] addr;
`ifdef MEM_ARB_RR_EN
        is_data = req_d && (!req_f || !ref_last);
`else
        is_data = req_d;
`endif
        is_store = is_data && we;
        addr     = is_data ? dd_addr : f_addr;
        exp_lat  = is_store ? 2 : LAT + 2;
        if_req = req_f; if_addr = f_addr;
        d_req = req_d; d_we = we; d_addr = dd_addr; d_wdata = wdata;
        seen = 0; n = 0; rd_n = 0; wr_n = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (mem_rd) rd_n++;
            if (mem_wr) wr_n++;
            if (n == 1) begin
                check("issue_busy", 64'(busy), 64'd1);
                check("issue_owner", 64'(owner), 64'(is_data));
                check("issue_rd", 64'(mem_rd), 64'(!is_store));
                check("issue_addr", mem_addr, addr);
                if (is_store) check("issue_wdata", mem_wdata, wdata);
                if (drop_early) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
            seen = if_done || d_done;
        end
        if (is_store) ref_mem[addr] = wdata;
        else if (is_data) exp_d_rdata = ref_read(addr);
        else exp_if_rdata = ref_read(addr);
        ref_last = is_data;
        check("latency", 64'(n), 64'(exp_lat));
        check("if_done", 64'(if_done), 64'(!is_data));
        check("d_done", 64'(d_done), 64'(is_data));
        check("if_rdata", if_rdata, exp_if_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        check("rd_strobes", 64'(rd_n), is_store ? 64'd0 : 64'd1);
        check("wr_strobes", 64'(wr_n), is_store ? 64'd1 : 64'd0);
        $display("txn port=%s we=%0d addr=%h latency=%0d", is_data ? "data" : "fetch", is_store, addr, n);
        if (is_data) d_req = 1'b0;
        else if_req = 1'b0;
        tick();
        check("post_idle_busy", 64'(busy), 64'd0);
        check("post_done_clear", 64'(if_done | d_done), 64'd0);
    endtask

    initial begin
        int strobes;
        // Reset held for 3 cycles: everything quiet
        reset = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_strobes", 64'(mem_rd | mem_wr), 64'd0);
        check("rst_dones", 64'(if_done | d_done), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_if_rdata", if_rdata, 64'd0);
        check("rst_d_rdata", d_rdata, 64'd0);
        reset = 1'b1;
        strobes = 0;
        repeat (4) begin
            tick();
            strobes += int'(mem_rd) + int'(mem_wr) + int'(busy);
        end
        check("idle_no_activity", 64'(strobes), 64'd0);
        $display("txn reset_release idle_activity=%0d", strobes);

        // Fetch of a known instruction word
        sim_mem[64'h100] = 64'h0050_0093;
        ref_mem[64'h100] = 64'h0050_0093;
        run_txn(1, 0, 0, 64'h100, 64'h0, 64'h0, 0);
        check("fetch_word", if_rdata, 64'h0050_0093);

        // Store, then tie between fetch and a load (data first, fetch granted in the IDLE cycle)
        run_txn(0, 1, 1, 64'h0, 64'h200, 64'hDEAD, 0);
        run_txn(1, 1, 0, 64'h100, 64'h208, 64'h0, 0);
        run_txn(1, 0, 0, 64'h100, 64'h0, 64'h0, 0);
        run_txn(0, 1, 0, 64'h0, 64'h200, 64'h0, 0);
        check("load_after_store", d_rdata, 64'hDEAD);

        // Both ports requesting repeatedly
        for (int i = 0; i < 4; i++) begin
            run_txn(1, 1, 0, 64'h110 + 64'(8 * i), 64'h300 + 64'(8 * i), 64'h0, 0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();

        // Asynchronous reset during the wait phase aborts the fetch
        if_req = 1'b1;
        if_addr = 64'h100;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rd", 64'(mem_rd), 64'd0);
        strobes = 0;
        repeat (3) begin
            tick();
            strobes += int'(if_done) + int'(d_done);
        end
        check("abort_no_done", 64'(strobes), 64'd0);
        check("abort_if_rdata", if_rdata, 64'd0);
        $display("txn abort_during_wait dones=%0d", strobes);
        if_req = 1'b0;
        reset = 1'b1;
        model_reset();
        tick();
        run_txn(1, 0, 0, 64'h104, 64'h0, 64'h0, 0);

        // Randomized traffic over a small address window so loads hit earlier stores
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [AW-1:0] a1, a2;
            kind = int'($urandom_range(0, 3));
            a1 = 64'h100 + 64'(8 * $urandom_range(0, 7));
            a2 = 64'h100 + 64'(8 * $urandom_range(0, 7));
            case (kind)
                0: run_txn(1, 0, 0, a1, a2, 64'h0, $urandom_range(0, 3) == 0);
                1: run_txn(0, 1, 0, a1, a2, 64'h0, $urandom_range(0, 3) == 0);
                2: run_txn(0, 1, 1, a1, a2, {$urandom, $urandom}, $urandom_range(0, 3) == 0);
                default: run_txn(1, 1, $urandom_range(0, 1) == 1, a1, a2, {$urandom, $urandom}, 0);
            endcase
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
